inst_seq_ctrl: RTL and testbench
================================

INST_SEQ_CTRL -- requirements
Module: inst_seq_ctrl

Interface
REQ-001 Parameter DATA_LEN, 32, width of PC and address datapath.
REQ-002 Parameter RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 if_req  output  1  fetch request to instruction memory, held until if_rvalid.
REQ-006 if_addr  output  DATA_LEN  fetch address, equals pc while if_req high.
REQ-007 if_rvalid  input  1  fetch data valid, one-cycle pulse.
REQ-008 if_rdata  input  32  fetched instruction word.
REQ-009 inst  output  32  latched instruction driving the decoder.
REQ-010 pc  output  DATA_LEN  PC of the instruction in inst.
REQ-011 dec_ebreak  input  1  decoder flag: inst is ebreak.
REQ-012 dec_jump  input  1  decoder flag: inst is jal/jalr.
REQ-013 jump_target  input  DATA_LEN  next PC computed from operand3+operand4.
REQ-014 exu_start  output  1  one-cycle pulse starting execution.
REQ-015 exu_done  input  1  execution complete, one-cycle pulse (latency 1..N).
REQ-016 rf_wen  output  1  register-file write enable, one-cycle pulse.
REQ-017 retire  output  1  one-cycle pulse per committed instruction.
REQ-018 halt  output  1  high and sticky once ebreak commits.

Function
REQ-019 FSM states SHALL be FETCH, DECODE, EXEC, WB, HALT.
REQ-020 FETCH: if_req=1; on if_rvalid latch inst<=if_rdata, go DECODE; else stay.
REQ-021 DECODE: one cycle; if dec_ebreak go HALT, else pulse exu_start and go EXEC.
REQ-022 EXEC: wait for exu_done, including done in the cycle after exu_start; then go WB.
REQ-023 WB: pulse rf_wen and retire; pc<=jump_target if dec_jump else pc+4 (mod 2^DATA_LEN); go FETCH.
REQ-024 HALT: halt=1, retire pulses once on entry, no further if_req/exu_start/rf_wen; exit only by reset.
REQ-025 Minimum instruction latency SHALL be 4 cycles (FETCH with same-cycle... rvalid, DECODE, EXEC with done next cycle, WB).
REQ-026 if_rvalid outside FETCH and exu_done outside EXEC SHALL be ignored.
REQ-027 inst and pc SHALL remain stable from DECODE through WB.
REQ-028 pc wrap from 32'hFFFF_FFFC +4 SHALL yield 0 without error.

Reset
REQ-029 rst_n low SHALL immediately force state FETCH, pc=RESET_PC, inst=32'h0000_0013 (nop), halt=0.
REQ-030 All pulse outputs (exu_start, rf_wen, retire) SHALL be 0 during reset; if_req rises first cycle after release.
REQ-031 Reset mid-fetch or mid-exec SHALL abandon the transaction; late if_rvalid/exu_done are ignored per REQ-026.

Configuration
REQ-032 Macro NPC_PERF_CNT_EN SHALL add outputs cycle_cnt and inst_cnt (64 bits each).
REQ-033 With macro: cycle_cnt increments every non-HALT cycle, inst_cnt on each retire; both reset to 0, wrap silently.
REQ-034 Without macro: ports and counters absent; behaviour otherwise identical.

Structure
REQ-035 Shared package SHALL hold the FSM state encoding, RESET_PC default and the nop encoding constant.
REQ-036 Performance counters SHALL be one sub-module, perf_cnt, instantiated only under NPC_PERF_CNT_EN.
REQ-037 The decoder SHALL remain a separate instance; this block only sequences it.

Verification
REQ-038 Release reset, if_rvalid same cycle as if_req with addi -> if_addr=8000_0000, rf_wen/retire in cycle 4, next if_addr=8000_0004.
REQ-039 Fetch jal, dec_jump=1, jump_target=8000_0100 -> next if_addr=8000_0100.
REQ-040 exu_done delayed 10 cycles -> state holds EXEC, no rf_wen, single rf_wen after done.
REQ-041 Fetch 32'h0010_0073 -> halt=1 two cycles later, no exu_start, if_req stays 0 for 100 cycles.
REQ-042 Assert rst_n low while in EXEC, then pulse exu_done during reset -> pc=8000_0000, no retire, fetch restarts.
REQ-043 With NPC_PERF_CNT_EN, run 5 instructions then ebreak -> inst_cnt=6, cycle_cnt stops at halt.

Source files
------------

// File: rtl/inst_seq_ctrl_pkg.sv
// Shared constants for the instruction sequencer: FSM state encoding,
// default reset PC and the nop instruction loaded into inst on reset.
package inst_seq_ctrl_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] S_FETCH  = 3'd0;
   localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
   localparam logic [STATE_W-1:0] S_EXEC   = 3'd2;
   localparam logic [STATE_W-1:0] S_WB     = 3'd3;
   localparam logic [STATE_W-1:0] S_HALT   = 3'd4;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;

endpackage

// File: rtl/inst_seq_ctrl_perf_cnt.sv
// Free-running 64-bit cycle and retired-instruction counters; both wrap silently.
module perf_cnt #(
   parameter int unsigned CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             count_cycle,
   input  logic             count_inst,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] inst_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         inst_cnt  <= '0;
      end else begin
         if (count_cycle) cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (count_inst)  inst_cnt  <= inst_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/inst_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for a single-issue core.
// Optional macro NPC_PERF_CNT_EN adds 64-bit cycle_cnt / inst_cnt outputs.
module inst_seq_ctrl
   import inst_seq_ctrl_pkg::*;
#(
   parameter int unsigned          DATA_LEN = 32,
   parameter logic [DATA_LEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                if_req,
   output logic [DATA_LEN-1:0] if_addr,
   input  logic                if_rvalid,
   input  logic [31:0]         if_rdata,
   output logic [31:0]         inst,
   output logic [DATA_LEN-1:0] pc,
   input  logic                dec_ebreak,
   input  logic                dec_jump,
   input  logic [DATA_LEN-1:0] jump_target,
   output logic                exu_start,
   input  logic                exu_done,
   output logic                rf_wen,
   output logic                retire,
`ifdef NPC_PERF_CNT_EN
   output logic [63:0]         cycle_cnt,
   output logic [63:0]         inst_cnt,
`endif
   output logic                halt
);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic               halt_retired;

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  if (if_rvalid) state_nxt = S_DECODE;
         S_DECODE: state_nxt = dec_ebreak ? S_HALT : S_EXEC;
         S_EXEC:   if (exu_done) state_nxt = S_WB;
         S_WB:     state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_FETCH;
         pc           <= RESET_PC;
         inst         <= NOP_INST;
         halt_retired <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH && if_rvalid) inst <= if_rdata;
         if (state == S_WB) pc <= dec_jump ? jump_target : pc + DATA_LEN'(4);
         if (state == S_HALT) halt_retired <= 1'b1;
      end
   end

   // Gated by rst_n so the request stays low while reset is held.
   assign if_req    = rst_n && (state == S_FETCH);
   assign if_addr   = pc;
   assign exu_start = (state == S_DECODE) && !dec_ebreak;
   assign rf_wen    = (state == S_WB);
   // The ebreak commits on the first HALT cycle only.
   assign retire    = (state == S_WB) || ((state == S_HALT) && !halt_retired);
   assign halt      = (state == S_HALT);

`ifdef NPC_PERF_CNT_EN
   perf_cnt #(
      .CNT_W (64)
   ) u_perf_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .count_cycle (state != S_HALT),
      .count_inst  (retire),
      .cycle_cnt   (cycle_cnt),
      .inst_cnt    (inst_cnt)
   );
`endif

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Scoreboard bench for inst_seq_ctrl: the bench plays instruction memory,
// decoder and execution unit; retired PCs are checked against a queue.
module tb_inst_seq_ctrl;

   localparam logic [31:0] RST_PC  = 32'h8000_0000;
   localparam logic [31:0] I_ADDI  = 32'h0010_0093;
   localparam logic [31:0] I_JAL   = 32'h1000_006f;
   localparam logic [31:0] I_EBRK  = 32'h0010_0073;
   localparam logic [31:0] I_NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_rvalid = 1'b0;
   logic [31:0] if_rdata = '0;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        dec_ebreak = 1'b0;
   logic        dec_jump = 1'b0;
   logic [31:0] jump_target = '0;
   logic        exu_start;
   logic        exu_done = 1'b0;
   logic        rf_wen;
   logic        retire;
   logic        halt;
`ifdef NPC_PERF_CNT_EN
   logic [63:0] cycle_cnt;
   logic [63:0] inst_cnt;
   logic [63:0] tb_cyc;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model_pc = RST_PC;
   int unsigned model_inst = 0;
   logic        tb_halted = 1'b0;

   always #5 clk = ~clk;

   inst_seq_ctrl #(
      .DATA_LEN (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_rvalid   (if_rvalid),
      .if_rdata    (if_rdata),
      .inst        (inst),
      .pc          (pc),
      .dec_ebreak  (dec_ebreak),
      .dec_jump    (dec_jump),
      .jump_target (jump_target),
      .exu_start   (exu_start),
      .exu_done    (exu_done),
      .rf_wen      (rf_wen),
      .retire      (retire),
`ifdef NPC_PERF_CNT_EN
      .cycle_cnt   (cycle_cnt),
      .inst_cnt    (inst_cnt),
`endif
      .halt        (halt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

`ifdef NPC_PERF_CNT_EN
   // Non-HALT cycles since reset release, as seen by the bench's own sequencing.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tb_cyc <= '0;
      else if (!tb_halted) tb_cyc <= tb_cyc + 64'd1;
   end
`endif

   always @(negedge clk) begin
      if (retire) begin
         if (exp_q.size() == 0) check("retire_unexpected", 1, 0);
         else check("retire_pc", pc, exp_q.pop_front());
      end
   end

   task automatic wait_if_req();
      for (int i = 0; i < 20 && !if_req; i++) @(negedge clk);
      check("if_req_wait", if_req, 1);
   endtask

   task automatic run_inst(input logic [31:0] instr, input logic ebreak, input logic jump,
                           input logic [31:0] target, input int unsigned delay);
      int unsigned bad;
      wait_if_req();
      check("if_addr", if_addr, model_pc);
      exp_q.push_back(model_pc);
      model_inst++;
      if_rvalid = 1'b1;
      if_rdata  = instr;
      @(negedge clk);
      if_rvalid   = 1'b0;
      dec_ebreak  = ebreak;
      dec_jump    = jump;
      jump_target = target;
      #1;
      check("exu_start", exu_start, !ebreak);
      check("inst_dec", inst, instr);
      check("pc_dec", pc, model_pc);
      check("if_req_dec", if_req, 0);
      if (ebreak) begin
         @(negedge clk);
         tb_halted = 1'b1;
         #1;
         check("halt", halt, 1);
`ifdef NPC_PERF_CNT_EN
         check("cycle_cnt_halt", cycle_cnt, tb_cyc);
`endif
         bad = 0;
         repeat (100) begin
            @(negedge clk);
            if (if_req || exu_start || rf_wen || retire) bad++;
         end
         check("halt_quiet", bad, 0);
         check("halt_sticky", halt, 1);
`ifdef NPC_PERF_CNT_EN
         check("cycle_cnt_frozen", cycle_cnt, tb_cyc);
         check("inst_cnt", inst_cnt, 64'(model_inst));
`endif
         return;
      end
      @(negedge clk);
      bad = 0;
      for (int unsigned i = 0; i < delay; i++) begin
         if (rf_wen || retire) bad++;
         if_rvalid = (i == 1);
         if_rdata  = 32'hdead_beef;
         @(negedge clk);
      end
      if_rvalid = 1'b0;
      check("exec_hold", bad, 0);
      exu_done = 1'b1;
      @(negedge clk);
      exu_done = 1'b0;
      #1;
      check("rf_wen", rf_wen, 1);
      check("pc_wb", pc, model_pc);
      check("inst_wb", inst, instr);
      model_pc = jump ? target : model_pc + 32'd4;
      @(negedge clk);
      dec_jump = 1'b0;
      #1;
      check("rf_wen_once", rf_wen, 0);
      check("if_addr_next", if_addr, model_pc);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_if_req", if_req, 0);
      check("rst_pc", pc, RST_PC);
      check("rst_inst", inst, I_NOP);
      check("rst_halt", halt, 0);
      check("rst_pulses", {exu_start, rf_wen, retire}, 0);
`ifdef NPC_PERF_CNT_EN
      check("rst_cycle_cnt", cycle_cnt, 0);
      check("rst_inst_cnt", inst_cnt, 0);
`endif
      rst_n = 1'b1;

      run_inst(I_ADDI, 1'b0, 1'b0, '0, 0);
      run_inst(I_JAL,  1'b0, 1'b1, 32'h8000_0100, 0);
      run_inst(I_ADDI, 1'b0, 1'b0, '0, 10);
      run_inst(I_JAL,  1'b0, 1'b1, 32'hFFFF_FFFC, 2);
      run_inst(I_ADDI, 1'b0, 1'b0, '0, 1);
      check("pc_wrap", pc, 32'h0);

      // Reset while in EXEC; exu_done during reset must be ignored.
      wait_if_req();
      if_rvalid = 1'b1;
      if_rdata  = I_ADDI;
      @(negedge clk);
      if_rvalid = 1'b0;
      @(negedge clk);
      rst_n    = 1'b0;
      exu_done = 1'b1;
      #1;
      check("mid_rst_pc", pc, RST_PC);
      check("mid_rst_inst", inst, I_NOP);
      check("mid_rst_if_req", if_req, 0);
      @(negedge clk);
      check("mid_rst_pulses", {exu_start, rf_wen, retire}, 0);
      exu_done = 1'b0;
      @(negedge clk);
      rst_n      = 1'b1;
      model_pc   = RST_PC;
      model_inst = 0;
      #1;
      check("restart_if_req", if_req, 1);
      check("restart_addr", if_addr, RST_PC);

      run_inst(I_ADDI, 1'b0, 1'b0, '0, 0);
      run_inst(I_ADDI, 1'b0, 1'b0, '0, 1);
      run_inst(I_ADDI, 1'b0, 1'b0, '0, 2);
      run_inst(I_ADDI, 1'b0, 1'b0, '0, 0);
      run_inst(I_ADDI, 1'b0, 1'b0, '0, 3);
      run_inst(I_EBRK, 1'b1, 1'b0, '0, 0);
      check("sb_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
